apb_master_arbiter: RTL and testbench

- Shares the single APB master port of the bus system between NUM_REQ local requesters, e.g. the CPU-side sequencer and a PWM auto-reload engine.
- Accepts simple valid/ready requests and arbitrates round-robin.
- Drives compliant APB SETUP/ACCESS phases, waits on PREADY, and returns PRDATA/PSLAVEERR to the winning requester.
- Sits directly in front of the bus decoder that feeds the multiplier and PWM slaves.

---
 rtl/apb_arb_pkg.sv | 34 +++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/apb_master_arbiter.sv | 176 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter.
// Optional access timeout is enabled with the APB_TIMEOUT_EN macro.
package apb_arb_pkg;

    localparam int ARB_ADDR_W         = 32;
    localparam int ARB_DATA_W         = 32;
    localparam int ARB_IDX_W          = 3;
    localparam int ARB_MAX_REQ        = 8;
    localparam int TIMEOUT_CYCLES_DEF = 64;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } arb_state_t;

    typedef logic [ARB_IDX_W-1:0] grant_idx_t;

    // Request copy taken at grant time; the requester is free to change
    // its inputs once it has seen req_ready.
    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic                  write;
        logic [ARB_DATA_W-1:0] wdata;
        grant_idx_t            idx;
    } req_latch_t;

    // Advance a requester index by one, wrapping at n.
    function automatic grant_idx_t next_idx(input grant_idx_t cur, input int n);
        return (int'(cur) >= n - 1) ? '0 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from last_grant+1 upward
// (wrapping) and returns the first pending requester.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  grant_idx_t         last_grant,
    output logic [NUM_REQ-1:0] grant,
    output grant_idx_t         grant_idx,
    output logic               any_valid
);

    logic [ARB_MAX_REQ-1:0] req_pad;
    grant_idx_t             cand;

    assign req_pad = ARB_MAX_REQ'(req);

    // Walk the requesters in rotated priority order and keep the first hit.
    always_comb begin
        cand      = last_grant;
        grant_idx = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = next_idx(cand, NUM_REQ);
            if (!any_valid && req_pad[cand]) begin
                any_valid = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Expand the winning index to a one-hot grant vector.
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = any_valid && (grant_idx == ARB_IDX_W'(i));
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ valid/ready requesters with
// round-robin arbitration. One transfer at a time, no pipelining.
// Define APB_TIMEOUT_EN to abort ACCESS phases that never see PREADY.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = ARB_ADDR_W,
    parameter int DATA_WIDTH     = ARB_DATA_W,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                                PCLK,
    input  logic                                PRESETn,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ-1:0]                  req_write,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  resp_valid,
    output logic [DATA_WIDTH-1:0]               resp_rdata,
    output logic                                resp_err,
    output logic [ADDR_WIDTH-1:0]               PADDR,
    output logic                                PSEL,
    output logic                                PENABLE,
    output logic                                PWRITE,
    output logic [DATA_WIDTH-1:0]               PWDATA,
    input  logic                                PREADY,
    input  logic [DATA_WIDTH-1:0]               PRDATA,
    input  logic                                PSLAVEERR
);

    if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ || ADDR_WIDTH > ARB_ADDR_W ||
        DATA_WIDTH > ARB_DATA_W || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("apb_master_arbiter: parameter out of supported range");
    end

    arb_state_t           state, state_n;
    req_latch_t           lat, lat_n;
    grant_idx_t           last_grant, last_grant_n;
    logic [NUM_REQ-1:0]   arb_grant;
    grant_idx_t           arb_idx;
    logic                 arb_any;
    logic                 psel_n, penable_n, resp_err_n, finish;
    logic [NUM_REQ-1:0]   req_ready_n, resp_valid_n;
    logic [DATA_WIDTH-1:0] resp_rdata_n;

`ifdef APB_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer, timer_n;
`endif

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any_valid  (arb_any)
    );

    // The bus-facing address/direction/data come straight from the latch
    // flops, so they stay put for the whole transfer.
    assign PADDR  = lat.addr[ADDR_WIDTH-1:0];
    assign PWRITE = lat.write;
    assign PWDATA = lat.wdata[DATA_WIDTH-1:0];

    // Next-state and next-output decode; bus phases appear one cycle after
    // the state that decides them because every output is a flop.
    always_comb begin
        state_n      = state;
        lat_n        = lat;
        last_grant_n = last_grant;
        psel_n       = PSEL;
        penable_n    = PENABLE;
        req_ready_n  = '0;
        resp_valid_n = '0;
        resp_rdata_n = resp_rdata;
        resp_err_n   = resp_err;
        finish       = 1'b0;
`ifdef APB_TIMEOUT_EN
        timer_n      = timer;
`endif
        case (state)
            IDLE: begin
                if (arb_any) begin
                    lat_n = '0;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_grant[i]) begin
                            lat_n.addr  = ARB_ADDR_W'(req_addr[i]);
                            lat_n.write = req_write[i];
                            lat_n.wdata = ARB_DATA_W'(req_wdata[i]);
                        end
                    end
                    lat_n.idx    = arb_idx;
                    req_ready_n  = arb_grant;
                    last_grant_n = arb_idx;
                    state_n      = SETUP;
`ifdef APB_TIMEOUT_EN
                    timer_n      = '0;
`endif
                end
            end
            SETUP: begin
                psel_n    = 1'b1;
                penable_n = 1'b0;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (!PENABLE) begin
                    penable_n = 1'b1;
                end else if (PREADY) begin
                    finish       = 1'b1;
                    resp_rdata_n = lat.write ? '0 : PRDATA;
                    resp_err_n   = PSLAVEERR;
                end
`ifdef APB_TIMEOUT_EN
                else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    finish       = 1'b1;
                    resp_rdata_n = '0;
                    resp_err_n   = 1'b1;
                end else begin
                    timer_n = timer + 1'b1;
                end
`endif
                if (finish) begin
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    state_n   = RESP;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        resp_valid_n[i] = (lat.idx == ARB_IDX_W'(i));
                    end
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset; the
    // pointer resets to the last requester so requester 0 wins first.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state      <= IDLE;
            lat        <= '0;
            last_grant <= grant_idx_t'(NUM_REQ - 1);
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
            timer      <= '0;
`endif
        end else begin
            state      <= state_n;
            lat        <= lat_n;
            last_grant <= last_grant_n;
            PSEL       <= psel_n;
            PENABLE    <= penable_n;
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
`ifdef APB_TIMEOUT_EN
            timer      <= timer_n;
`endif
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: directed requests push expected
// grants/responses, a monitor pops and compares as the DUT presents them.
// Build with APB_TIMEOUT_EN to also exercise the ACCESS timeout.
module tb_apb_master_arbiter;

    localparam int NREQ = 2;
    localparam int TO   = 8;

    logic                  PCLK = 1'b0;
    logic                  PRESETn;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0][31:0] req_addr;
    logic [NREQ-1:0]       req_write;
    logic [NREQ-1:0][31:0] req_wdata;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic [31:0]           PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [31:0]           PWDATA;
    logic                  PREADY;
    logic [31:0]           PRDATA;
    logic                  PSLAVEERR;

    typedef struct {
        bit [0:0]    idx;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } grant_t;

    typedef struct {
        bit [0:0]    idx;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    grant_t      exp_grants[$];
    resp_t       exp_resps[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    bit          mon_en     = 1'b0;
    int          slave_wait = 0;
    logic [31:0] slave_rdata = '0;
    logic        slave_err  = 1'b0;

    apb_master_arbiter #(
        .NUM_REQ        (NREQ),
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_write  (req_write),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PREADY     (PREADY),
        .PRDATA     (PRDATA),
        .PSLAVEERR  (PSLAVEERR)
    );

    initial forever #5 PCLK = ~PCLK;

    initial forever begin
        @(posedge PCLK);
        cyc = cyc + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectTxn(input bit [0:0] idx, input logic [31:0] addr, input logic write,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic err, input bit with_resp);
        grant_t g;
        resp_t  r;
        g.idx = idx; g.addr = addr; g.write = write; g.wdata = wdata;
        exp_grants.push_back(g);
        if (with_resp) begin
            r.idx = idx; r.rdata = rdata; r.err = err;
            exp_resps.push_back(r);
        end
    endtask

    // Present one request and hold it until the arbiter accepts it.
    task automatic applyStimulus(input bit [0:0] idx, input logic [31:0] addr,
                                 input logic write, input logic [31:0] wdata);
        bit seen = 1'b0;
        req_addr[idx]  = addr;
        req_write[idx] = write;
        req_wdata[idx] = wdata;
        req_valid[idx] = 1'b1;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge PCLK);
            if (req_ready[idx]) seen = 1'b1;
        end
        req_valid[idx] = 1'b0;
        if (!seen) checkOutput("req_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 300 && exp_resps.size() != 0; c++) @(negedge PCLK);
        if (exp_resps.size() != 0) checkOutput("drain_timeout", exp_resps.size(), 0);
    endtask

    task automatic countAccess(output int n);
        int c = 0;
        while (!(PSEL && PENABLE) && c < 50) begin
            @(negedge PCLK);
            c++;
        end
        n = 0;
        while (PSEL && PENABLE && n < 500) begin
            n++;
            @(negedge PCLK);
        end
    endtask

    // APB slave model: PREADY after slave_wait ACCESS cycles.
    initial begin
        int acc;
        acc = 0;
        PREADY = 1'b0; PRDATA = '0; PSLAVEERR = 1'b0;
        forever begin
            @(posedge PCLK);
            #1;
            if (PSEL && PENABLE) begin
                PREADY    = (acc >= slave_wait);
                PRDATA    = slave_rdata;
                PSLAVEERR = slave_err && (acc >= slave_wait);
                acc++;
            end else begin
                PREADY = 1'b0; PRDATA = '0; PSLAVEERR = 1'b0;
                acc = 0;
            end
        end
    end

    // Monitor: grants, APB phase sequencing, bus stability and responses.
    initial begin
        int     ready_cyc;
        logic   psel_d;
        grant_t cur;
        grant_t g;
        resp_t  r;
        ready_cyc = 0;
        psel_d    = 1'b0;
        cur = '{idx: 1'b0, addr: 32'h0, write: 1'b0, wdata: 32'h0};
        forever begin
            @(negedge PCLK);
            if (mon_en) begin
                if (req_ready != '0) begin
                    if (exp_grants.size() == 0) begin
                        checkOutput("unexpected_grant", req_ready, 0);
                    end else begin
                        g = exp_grants.pop_front();
                        checkOutput("grant_onehot", req_ready, 2'b01 << g.idx);
                        cur = g;
                        ready_cyc = cyc;
                    end
                end
                if (PSEL && !psel_d) begin
                    checkOutput("setup_penable", PENABLE, 0);
                    checkOutput("psel_latency", cyc - ready_cyc, 1);
                end
                if (PSEL && psel_d) checkOutput("access_penable", PENABLE, 1);
                if (PSEL) begin
                    checkOutput("bus_addr_dir", {PWRITE, PADDR}, {cur.write, cur.addr});
                    if (cur.write) checkOutput("bus_wdata", PWDATA, cur.wdata);
                end
                if (resp_valid != '0) begin
                    if (exp_resps.size() == 0) begin
                        checkOutput("unexpected_resp", resp_valid, 0);
                    end else begin
                        r = exp_resps.pop_front();
                        checkOutput("resp_onehot", resp_valid, 2'b01 << r.idx);
                        checkOutput("resp_rdata", resp_rdata, r.rdata);
                        checkOutput("resp_err", resp_err, r.err);
                        checkOutput("resp_psel_low", {PSEL, PENABLE}, 0);
                    end
                end
            end
            psel_d = PSEL;
        end
    end

    initial begin
        int n;
        PRESETn   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        repeat (3) @(negedge PCLK);

        $display("[TB] reset values");
        checkOutput("rst_psel", PSEL, 0);
        checkOutput("rst_penable", PENABLE, 0);
        checkOutput("rst_pwrite", PWRITE, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_resp_err", resp_err, 0);
        checkOutput("rst_paddr", PADDR, 0);
        checkOutput("rst_pwdata", PWDATA, 0);
        checkOutput("rst_resp_rdata", resp_rdata, 0);
        PRESETn = 1'b1;
        mon_en  = 1'b1;

        $display("[TB] single write from requester 0");
        slave_wait = 0; slave_rdata = 32'h1234_5678;
        expectTxn(1'b0, 32'h0FF0, 1'b1, 32'd5, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0FF0, 1'b1, 32'd5);
        drain();

        $display("[TB] read from requester 1 with 6 wait cycles");
        slave_wait = 6; slave_rdata = 32'd20;
        expectTxn(1'b1, 32'h0008, 1'b0, 32'h0, 32'd20, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h0008, 1'b0, 32'h0);
        countAccess(n);
        checkOutput("read_access_cycles", n, 7);
        drain();

        $display("[TB] slave error");
        slave_wait = 0; slave_err = 1'b1; slave_rdata = 32'hDEAD_0000;
        expectTxn(1'b1, 32'h5000, 1'b1, 32'h77, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h5000, 1'b1, 32'h77);
        drain();
        slave_err = 1'b0;

        $display("[TB] contention, both requesters continuously valid");
        slave_wait = 1; slave_rdata = 32'h0000_BEEF;
        for (int k = 0; k < 4; k++) begin
            expectTxn(1'b0, 32'h1000 + 4 * k, 1'b1, 32'h100 + k, 32'h0, 1'b0, 1'b1);
            expectTxn(1'b1, 32'h02C4, 1'b0, 32'h0, 32'h0000_BEEF, 1'b0, 1'b1);
        end
        fork
            begin
                for (int k = 0; k < 4; k++) applyStimulus(1'b0, 32'h1000 + 4 * k, 1'b1, 32'h100 + k);
            end
            begin
                for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h02C4, 1'b0, 32'h0);
            end
        join
        drain();

        $display("[TB] reset during ACCESS");
        slave_wait = 100000;
        expectTxn(1'b0, 32'h0040, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0040, 1'b0, 32'h0);
        repeat (3) @(negedge PCLK);
        checkOutput("pre_reset_access", {PSEL, PENABLE}, 2'b11);
        PRESETn = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        checkOutput("reset_bus_idle", {PSEL, PENABLE}, 0);
        checkOutput("reset_no_resp", resp_valid, 0);
        slave_wait = 0;
        repeat (6) @(negedge PCLK);
        expectTxn(1'b0, 32'h0060, 1'b1, 32'h11, 32'h0, 1'b0, 1'b1);
        expectTxn(1'b1, 32'h0064, 1'b0, 32'h0, 32'h0000_BEEF, 1'b0, 1'b1);
        fork
            applyStimulus(1'b0, 32'h0060, 1'b1, 32'h11);
            applyStimulus(1'b1, 32'h0064, 1'b0, 32'h0);
        join
        drain();

`ifdef APB_TIMEOUT_EN
        $display("[TB] ACCESS timeout");
        slave_wait = 100000; slave_rdata = 32'hAAAA_5555;
        expectTxn(1'b0, 32'h0088, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0088, 1'b0, 32'h0);
        countAccess(n);
        checkOutput("timeout_access_cycles", n, TO);
        drain();
        slave_wait = 0;
`endif

        repeat (3) @(negedge PCLK);
        checkOutput("grants_left", exp_grants.size(), 0);
        checkOutput("resps_left", exp_resps.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
